// File: rtl/rrag_pkg.sv
// rrag_pkg: shared encodings for the RrAg-stage string-repeat address sequencer.
// Contents: opsize codes, repeat-termination codes, sequencer state encoding,
// and small helpers that decode the termination mode.
package rrag_pkg;

  // Element size per iteration; the address step is 1 << opsize bytes.
  localparam logic [1:0] OPSIZE_1B = 2'b00;
  localparam logic [1:0] OPSIZE_2B = 2'b01;
  localparam logic [1:0] OPSIZE_4B = 2'b10;
  localparam logic [1:0] OPSIZE_8B = 2'b11;

  // Repeat termination: count only, REPE (stop on ZF=0), REPNE (stop on ZF=1).
  // The reserved code behaves like count only.
  localparam logic [1:0] TERM_COUNT = 2'b00;
  localparam logic [1:0] TERM_REPE  = 2'b01;
  localparam logic [1:0] TERM_REPNE = 2'b10;
  localparam logic [1:0] TERM_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    REPSEQ_IDLE    = 2'b00,
    REPSEQ_RUN     = 2'b01,
    REPSEQ_WAIT_ZF = 2'b10
  } repseq_state_e;

  // True when each iteration must wait for its ZF before the next one issues.
  function automatic logic term_uses_zf(input logic [1:0] term);
    logic uses;
    case (term)
      TERM_REPE:  uses = 1'b1;
      TERM_REPNE: uses = 1'b1;
      default:    uses = 1'b0;
    endcase
    return uses;
  endfunction

  // True when the returned ZF ends the repeat under the given mode.
  function automatic logic term_zf_stop(input logic [1:0] term, input logic zf);
    logic stop;
    case (term)
      TERM_REPE:  stop = ~zf;
      TERM_REPNE: stop = zf;
      default:    stop = 1'b0;
    endcase
    return stop;
  endfunction

endpackage

// File: rtl/rep_addr_step.sv
// rep_addr_step: next address of one string channel.
// Ports:
//   i_addr   current channel address
//   i_opsize element size code; step = 1 << i_opsize
//   i_dir    0 = add step, 1 = subtract step (2's-complement negate of the step)
//   i_en     channel steps when 1, otherwise passes i_addr through
//   o_addr   stepped address, wrapping modulo 2^ADDR_W
module rep_addr_step #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_opsize,
  input  logic              i_dir,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_delta;

  // Build the signed step and apply it; a decrement is an add of the negated step.
  always_comb begin
    w_step  = ADDR_W'(1'b1) << i_opsize;
    if (i_dir) begin
      w_delta = ~w_step + ADDR_W'(1'b1);
    end else begin
      w_delta = w_step;
    end
    if (i_en) begin
      o_addr = i_addr + w_delta;
    end else begin
      o_addr = i_addr;
    end
  end

endmodule

// File: rtl/rep_addr_seq.sv
// rep_addr_seq: sequences REP/REPE/REPNE string iterations for NUM_CH address
// channels in the RrAg stage. The first access is issued combinationally in the
// accept cycle; later accesses come from the address registers.
// Ports:
//   clk, clr            clock; asynchronous active-low reset
//   valid_in, is_rep    instruction present / carries a REP prefix
//   base_addr, ch_en    per-channel start address (ch0 in LSBs) and step enable
//   count_in, opsize    repeat count and element size
//   dir, term_mode      direction flag and termination mode
//   zf_valid, zf_in     ZF of the last issued iteration
//   ready_in, flush     downstream accept; synchronous abort
//   mem_addr, addr_valid  per-channel access address and its valid
//   rep_stall, done       hold upstream; one-cycle retire pulse
//   remaining             current repeat count
module rep_addr_seq
  import rrag_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     valid_in,
  input  logic                     is_rep,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [CNT_W-1:0]         count_in,
  input  logic [1:0]               opsize,
  input  logic                     dir,
  input  logic [1:0]               term_mode,
  input  logic                     zf_valid,
  input  logic                     zf_in,
  input  logic                     ready_in,
  input  logic                     flush,
  output logic [NUM_CH*ADDR_W-1:0] mem_addr,
  output logic                     addr_valid,
  output logic                     rep_stall,
  output logic                     done,
  output logic [CNT_W-1:0]         remaining
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  repseq_state_e             r_state, w_state_seq, w_state_nx;
  logic [CNT_W-1:0]          r_cnt, w_cnt_seq, w_cnt_nx, w_remaining;
  logic [NUM_CH*ADDR_W-1:0]  r_addr, w_src, w_stepped;
  logic [1:0]                r_opsize, r_term, w_opsize;
  logic                      r_dir, w_dir;
  logic [NUM_CH-1:0]         r_ch_en, w_ch_en;
  logic                      w_idle;
  logic                      w_addr_we_seq, w_cfg_we_seq, w_addr_we, w_cfg_we;
  logic                      w_addr_valid, w_rep_stall, w_done_seq;

  assign w_idle = (r_state == REPSEQ_IDLE);

  // IDLE works from the live instruction; RUN/WAIT_ZF use what was captured at accept.
  assign w_src    = w_idle ? base_addr : r_addr;
  assign w_opsize = w_idle ? opsize    : r_opsize;
  assign w_dir    = w_idle ? dir       : r_dir;
  assign w_ch_en  = w_idle ? ch_en     : r_ch_en;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rep_addr_step #(.ADDR_W(ADDR_W)) u_step (
      .i_addr   (w_src[g*ADDR_W +: ADDR_W]),
      .i_opsize (w_opsize),
      .i_dir    (w_dir),
      .i_en     (w_ch_en[g]),
      .o_addr   (w_stepped[g*ADDR_W +: ADDR_W])
    );
  end

  // Next-state and output decode of the repeat sequencer (flush applied afterwards).
  always_comb begin
    w_state_seq   = r_state;
    w_cnt_seq     = r_cnt;
    w_addr_we_seq = 1'b0;
    w_cfg_we_seq  = 1'b0;
    w_addr_valid  = 1'b0;
    w_rep_stall   = 1'b0;
    w_done_seq    = 1'b0;
    w_remaining   = CNT_ZERO;
    case (r_state)
      REPSEQ_IDLE: begin
        if (valid_in && !is_rep) begin
          w_addr_valid = 1'b1;
        end else if (valid_in && (count_in == CNT_ZERO)) begin
          // Zero-count REP retires without touching memory.
          w_done_seq = 1'b1;
        end else if (valid_in) begin
          w_addr_valid = 1'b1;
          w_remaining  = count_in;
          if (ready_in && (count_in == CNT_ONE)) begin
            w_done_seq = 1'b1;
          end else if (ready_in) begin
            w_rep_stall   = 1'b1;
            w_cnt_seq     = count_in - CNT_ONE;
            w_addr_we_seq = 1'b1;
            w_cfg_we_seq  = 1'b1;
            w_state_seq   = term_uses_zf(term_mode) ? REPSEQ_WAIT_ZF : REPSEQ_RUN;
          end else begin
            w_state_seq = REPSEQ_IDLE;
          end
        end else begin
          w_state_seq = REPSEQ_IDLE;
        end
      end
      REPSEQ_RUN: begin
        w_addr_valid = 1'b1;
        w_rep_stall  = 1'b1;
        w_remaining  = r_cnt;
        if (ready_in) begin
          w_cnt_seq     = r_cnt - CNT_ONE;
          w_addr_we_seq = 1'b1;
          if (r_cnt == CNT_ONE) begin
            w_rep_stall = 1'b0;
            w_done_seq  = 1'b1;
            w_state_seq = REPSEQ_IDLE;
          end else if (term_uses_zf(r_term)) begin
            w_state_seq = REPSEQ_WAIT_ZF;
          end else begin
            w_state_seq = REPSEQ_RUN;
          end
        end else begin
          w_state_seq = REPSEQ_RUN;
        end
      end
      REPSEQ_WAIT_ZF: begin
        w_rep_stall = 1'b1;
        w_remaining = r_cnt;
        if (zf_valid && term_zf_stop(r_term, zf_in)) begin
          w_rep_stall = 1'b0;
          w_done_seq  = 1'b1;
          w_state_seq = REPSEQ_IDLE;
        end else if (zf_valid) begin
          w_state_seq = REPSEQ_RUN;
        end else begin
          w_state_seq = REPSEQ_WAIT_ZF;
        end
      end
      default: begin
        w_state_seq = REPSEQ_IDLE;
      end
    endcase
  end

  // Flush only redirects the next state and suppresses retirement; visible outputs stand.
  assign w_state_nx = flush ? REPSEQ_IDLE : w_state_seq;
  assign w_cnt_nx   = flush ? CNT_ZERO : w_cnt_seq;
  assign w_addr_we  = w_addr_we_seq & ~flush;
  assign w_cfg_we   = w_cfg_we_seq & ~flush;

  assign mem_addr   = w_addr_valid ? w_src : {(NUM_CH*ADDR_W){1'b0}};
  assign addr_valid = w_addr_valid;
  assign rep_stall  = w_rep_stall;
  assign done       = w_done_seq & ~flush;
  assign remaining  = w_remaining;

  // Sequencer state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= REPSEQ_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Count, channel addresses and the instruction attributes captured at accept.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt    <= CNT_ZERO;
      r_addr   <= {(NUM_CH*ADDR_W){1'b0}};
      r_opsize <= 2'b00;
      r_term   <= 2'b00;
      r_dir    <= 1'b0;
      r_ch_en  <= {NUM_CH{1'b0}};
    end else begin
      r_cnt <= w_cnt_nx;
      if (w_addr_we) begin
        r_addr <= w_stepped;
      end
      if (w_cfg_we) begin
        r_opsize <= opsize;
        r_term   <= term_mode;
        r_dir    <= dir;
        r_ch_en  <= ch_en;
      end
    end
  end

endmodule

// File: tb/tb_rep_addr_seq.sv
// tb_rep_addr_seq: directed scenarios plus randomized instructions, each cycle
// compared against an iteration-count reference model of the repeat sequencer.
module tb_rep_addr_seq;

  logic        clk = 1'b0;
  logic        clr, valid_in, is_rep, dir, zf_valid, zf_in, ready_in, flush;
  logic [63:0] base_addr;
  logic [1:0]  ch_en, opsize, term_mode;
  logic [31:0] count_in;
  logic [63:0] mem_addr;
  logic        addr_valid, rep_stall, done;
  logic [31:0] remaining;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an instruction is busy with k iterations already issued.
  logic        m_busy = 1'b0, m_wait = 1'b0;
  int unsigned m_k = 0;
  logic [63:0] m_base;
  logic [1:0]  m_en, m_op, m_term;
  logic        m_dir;
  logic [31:0] m_cnt;
  logic        n_busy, n_wait;
  int unsigned n_k;
  logic        e_dn_s;

  rep_addr_seq #(.ADDR_W(32), .NUM_CH(2), .CNT_W(32)) dut (
    .clk(clk), .clr(clr), .valid_in(valid_in), .is_rep(is_rep), .base_addr(base_addr),
    .ch_en(ch_en), .count_in(count_in), .opsize(opsize), .dir(dir), .term_mode(term_mode),
    .zf_valid(zf_valid), .zf_in(zf_in), .ready_in(ready_in), .flush(flush),
    .mem_addr(mem_addr), .addr_valid(addr_valid), .rep_stall(rep_stall), .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic zf_mode(input logic [1:0] t);
    return (t == 2'b01) || (t == 2'b10);
  endfunction

  // Address of channel c after k steps, straight from base +/- k*size.
  function automatic logic [31:0] ch_addr(input int c, input int unsigned k);
    logic [31:0] b, off;
    b   = m_base[c*32 +: 32];
    off = k * (32'd1 << m_op);
    if (!m_en[c]) return b;
    return m_dir ? (b - off) : (b + off);
  endfunction

  // Compare outputs at the falling edge and work out the model's next state.
  task automatic sample();
    logic [63:0] e_addr;
    logic        e_av, e_st, e_dn;
    logic [31:0] e_rem, left;
    #4;
    e_addr = 64'd0; e_av = 1'b0; e_st = 1'b0; e_dn = 1'b0; e_rem = 32'd0;
    n_busy = m_busy; n_wait = m_wait; n_k = m_k;
    left = m_cnt - m_k;
    if (!m_busy) begin
      if (valid_in && !is_rep) begin
        e_av = 1'b1; e_addr = base_addr;
      end else if (valid_in && count_in == 32'd0) begin
        e_dn = 1'b1;
      end else if (valid_in) begin
        e_av = 1'b1; e_addr = base_addr; e_rem = count_in;
        if (ready_in && count_in == 32'd1) begin
          e_dn = 1'b1;
        end else if (ready_in) begin
          e_st = 1'b1; n_busy = 1'b1; n_k = 1; n_wait = zf_mode(term_mode);
          m_base = base_addr; m_en = ch_en; m_op = opsize; m_dir = dir;
          m_term = term_mode; m_cnt = count_in;
        end
      end
    end else if (!m_wait) begin
      e_av = 1'b1; e_st = 1'b1; e_rem = left;
      e_addr = {ch_addr(1, m_k), ch_addr(0, m_k)};
      if (ready_in) begin
        n_k = m_k + 1;
        if (left == 32'd1) begin
          e_st = 1'b0; e_dn = 1'b1; n_busy = 1'b0;
        end else begin
          n_wait = zf_mode(m_term);
        end
      end
    end else begin
      e_st = 1'b1; e_rem = left;
      if (zf_valid) begin
        if ((m_term == 2'b01 && !zf_in) || (m_term == 2'b10 && zf_in)) begin
          e_st = 1'b0; e_dn = 1'b1; n_busy = 1'b0;
        end else begin
          n_wait = 1'b0;
        end
      end
    end
    if (flush) begin
      e_dn = 1'b0; n_busy = 1'b0;
    end
    if (!clr) n_busy = 1'b0;
    e_dn_s = e_dn;
    chk("addr_valid", {63'd0, addr_valid}, {63'd0, e_av});
    chk("mem_addr", mem_addr, e_addr);
    chk("rep_stall", {63'd0, rep_stall}, {63'd0, e_st});
    chk("done", {63'd0, done}, {63'd0, e_dn});
    chk("remaining", {32'd0, remaining}, {32'd0, e_rem});
  endtask

  task automatic advance();
    m_busy = n_busy; m_wait = n_wait; m_k = n_k;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rep, input logic [63:0] base, input logic [1:0] en,
                           input logic [31:0] cnt, input logic [1:0] op, input logic d,
                           input logic [1:0] term);
    valid_in = 1'b1; is_rep = rep; base_addr = base; ch_en = en; count_in = cnt;
    opsize = op; dir = d; term_mode = term;
    ready_in = 1'b1; zf_valid = 1'b0; zf_in = 1'b0; flush = 1'b0;
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0; flush = 1'b0; zf_valid = 1'b0;
    sample();
    advance();
  endtask

  task automatic run_random_instr();
    int   cyc;
    logic fin;
    set_instr($urandom_range(0, 7) != 0, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? 32'd12 : 32'($urandom_range(0, 6)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 300) begin
      ready_in = ($urandom_range(0, 3) != 0);
      zf_valid = 1'($urandom_range(0, 1));
      zf_in    = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 24) == 0);
      sample();
      fin = e_dn_s || flush || !is_rep;
      advance();
      cyc++;
    end
    chk("rand_instr_end", {63'd0, fin}, 64'd1);
    repeat ($urandom_range(0, 2)) idle_cycle();
  endtask

  initial begin
    int acc;
    clr = 1'b0; valid_in = 1'b0; is_rep = 1'b0; base_addr = 64'd0; ch_en = 2'b00;
    count_in = 32'd0; opsize = 2'b00; dir = 1'b0; term_mode = 2'b00;
    zf_valid = 1'b0; zf_in = 1'b0; ready_in = 1'b0; flush = 1'b0;
    #6;
    sample();
    chk("rst_outputs", {mem_addr[31:0], 28'd0, addr_valid, rep_stall, done, 1'b0}, 64'd0);
    advance();
    clr = 1'b1;
    idle_cycle();

    // REP MOVSB, count 3, one access per cycle.
    set_instr(1'b1, 64'h00002000_00001000, 2'b11, 32'd3, 2'b00, 1'b0, 2'b00);
    sample(); chk("movsb_a1", mem_addr, 64'h00002000_00001000); chk("movsb_s1", {63'd0, rep_stall}, 64'd1); advance();
    sample(); chk("movsb_a2", mem_addr, 64'h00002001_00001001); chk("movsb_s2", {63'd0, rep_stall}, 64'd1); advance();
    sample(); chk("movsb_a3", mem_addr, 64'h00002002_00001002); chk("movsb_d3", {63'd0, done}, 64'd1);
    chk("movsb_s3", {63'd0, rep_stall}, 64'd0); advance();
    idle_cycle();

    // Decrement by 4 with wrap below zero; channel 1 disabled.
    set_instr(1'b1, 64'h00000100_00000002, 2'b01, 32'd2, 2'b10, 1'b1, 2'b00);
    sample(); chk("wrap_a1", {32'd0, mem_addr[31:0]}, 64'h2); chk("wrap_r1", {32'd0, remaining}, 64'd2); advance();
    sample(); chk("wrap_a2", {32'd0, mem_addr[31:0]}, 64'hFFFFFFFE); chk("wrap_r2", {32'd0, remaining}, 64'd1);
    chk("wrap_ch1", {32'd0, mem_addr[63:32]}, 64'h100); advance();
    valid_in = 1'b0;
    sample(); chk("wrap_r3", {32'd0, remaining}, 64'd0); advance();
    idle_cycle();

    // REPE, count 5: ZF=1 then ZF=0 ends after two accesses.
    set_instr(1'b1, 64'h00000800_00000400, 2'b11, 32'd5, 2'b01, 1'b0, 2'b01);
    acc = 0;
    zf_valid = 1'b1; zf_in = 1'b1;
    sample(); acc += int'(addr_valid); advance();
    sample(); acc += int'(addr_valid); advance();
    zf_in = 1'b0;
    sample(); acc += int'(addr_valid); advance();
    sample(); acc += int'(addr_valid);
    chk("repe_done", {63'd0, done}, 64'd1); chk("repe_rem", {32'd0, remaining}, 64'd3); advance();
    chk("repe_accesses", 64'(acc), 64'd2);
    idle_cycle();

    // Zero count: retire with no access in the same cycle.
    set_instr(1'b1, 64'h12345678_9ABCDEF0, 2'b11, 32'd0, 2'b00, 1'b0, 2'b00);
    sample(); chk("zero_av", {63'd0, addr_valid}, 64'd0); chk("zero_done", {63'd0, done}, 64'd1); advance();
    idle_cycle();

    // Backpressure in RUN: address and count hold, sequence resumes cleanly.
    set_instr(1'b1, 64'h00000020_00000010, 2'b11, 32'd4, 2'b01, 1'b0, 2'b00);
    sample(); advance();
    ready_in = 1'b0;
    sample(); advance();
    sample(); chk("hold_addr", mem_addr, 64'h00000022_00000012); chk("hold_rem", {32'd0, remaining}, 64'd3); advance();
    ready_in = 1'b1;
    repeat (3) begin sample(); advance(); end
    idle_cycle();

    // Flush on the second RUN cycle of a count-10 REP, then a plain access.
    set_instr(1'b1, 64'h00005000_00004000, 2'b11, 32'd10, 2'b00, 1'b0, 2'b00);
    sample(); advance();
    sample(); advance();
    flush = 1'b1;
    sample(); chk("flush_nodone", {63'd0, done}, 64'd0); chk("flush_stall", {63'd0, rep_stall}, 64'd1); advance();
    set_instr(1'b0, 64'hAAAA0000_BBBB0000, 2'b11, 32'd7, 2'b00, 1'b0, 2'b00);
    sample(); chk("post_flush_addr", mem_addr, 64'hAAAA0000_BBBB0000); chk("post_flush_stall", {63'd0, rep_stall}, 64'd0); advance();
    idle_cycle();

    // Reset asserted mid-run: immediate return to reset values, no done.
    set_instr(1'b1, 64'h00007000_00006000, 2'b11, 32'd10, 2'b00, 1'b0, 2'b00);
    sample(); advance();
    sample(); advance();
    clr = 1'b0; valid_in = 1'b0; m_busy = 1'b0; m_wait = 1'b0;
    sample(); chk("clr_stall", {63'd0, rep_stall}, 64'd0); chk("clr_done", {63'd0, done}, 64'd0); advance();
    clr = 1'b1;
    set_instr(1'b0, 64'h11110000_22220000, 2'b11, 32'd3, 2'b00, 1'b0, 2'b00);
    sample(); chk("post_clr_addr", mem_addr, 64'h11110000_22220000); advance();
    idle_cycle();

    // Randomized instructions against the model.
    repeat (60) run_random_instr();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
